// File: rtl/div_unit_if.sv
// Handshake/bus bundle for the iterative divider: request side driven by the
// master (pipeline), status/result side driven by the divider (slave).
`timescale 1ns/1ps
interface div_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      div_func;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, div_func, op1, op2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, div_func, op1, op2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// RV32M divider: restoring division, one quotient bit per clock (32 iterations).
// Divide-by-zero and signed overflow complete immediately with fixed results.
// Signed ops divide magnitudes and fix the signs on the final iteration.
`timescale 1ns/1ps
module div_unit #(
    parameter int XLEN = 32
) (
    input logic        clk,
    input logic        rst_n,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IT = 6'(XLEN - 1);

    state_t          r_state;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_dz;
    logic            w_ovf;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN-1:0] w_spec;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_sub;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_fin_q;
    logic [XLEN-1:0] w_fin_r;
    logic [XLEN-1:0] w_fin;

    // Two's-complement negation.
    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

    // Request decode: operand magnitudes and the two short-circuit cases.
    always_comb begin
        w_signed = ~bus.div_func[0];
        w_dz     = (bus.op2 == {XLEN{1'b0}});
        w_ovf    = w_signed & (bus.op1 == {1'b1, {(XLEN-1){1'b0}}})
                            & (bus.op2 == {XLEN{1'b1}});
        w_abs1   = (w_signed & bus.op1[XLEN-1]) ? neg2(bus.op1) : bus.op1;
        w_abs2   = (w_signed & bus.op2[XLEN-1]) ? neg2(bus.op2) : bus.op2;
        if (w_dz) begin
            w_spec = bus.div_func[1] ? bus.op1 : {XLEN{1'b1}};
        end else if (bus.div_func[1]) begin
            w_spec = {XLEN{1'b0}};
        end else begin
            w_spec = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One restoring step; the partial remainder is widened by one bit so the
    // trial subtraction keeps its sign.
    always_comb begin
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_sub   = w_shift - {1'b0, r_dvs};
        if (w_sub[XLEN]) begin
            w_rem_nxt = w_shift[XLEN-1:0];
            w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
        end else begin
            w_rem_nxt = w_sub[XLEN-1:0];
            w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
        end
        w_fin_q = r_neg_q ? neg2(w_quo_nxt) : w_quo_nxt;
        w_fin_r = r_neg_r ? neg2(w_rem_nxt) : w_rem_nxt;
        w_fin   = r_is_rem ? w_fin_r : w_fin_q;
    end

    // Control FSM with registered busy/done/result; flush aborts from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_rem    <= {XLEN{1'b0}};
            r_quo    <= {XLEN{1'b0}};
            r_dvs    <= {XLEN{1'b0}};
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_is_rem <= bus.div_func[1];
                        r_neg_q  <= w_signed & (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
                        r_neg_r  <= w_signed & bus.op1[XLEN-1];
                        r_rem    <= {XLEN{1'b0}};
                        r_quo    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_cnt    <= 6'd0;
                        if (w_dz || w_ovf) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= w_spec;
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST_IT) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_fin;
                    end else begin
                        r_state <= CALC;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the stimulus side pushes reference results,
// a negedge monitor pops and checks them whenever done is seen.
`timescale 1ns/1ps
module tb_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        bit          special;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          busy_cnt = 0;
    bit          prev_busy = 1'b0;
    logic [31:0] last_res = 32'h0000_0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: RV32M division rules written with plain integer arithmetic.
    function automatic logic [31:0] ref_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        bit sg;
        bit rm;
        sg = !f[0];
        rm = f[1];
        sa = a;
        sb = b;
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
        if (sg) return rm ? 32'(sa % sb) : 32'(sa / sb);
        return rm ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Drive a request at a negedge and record its expected outcome.
    task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.div_func = f;
        bus.op1      = a;
        bus.op2      = b;
        e.res        = ref_op(f, a, b);
        e.special    = is_special(f, a, b);
        exp_q.push_back(e);
    endtask

    // Launch, pass E0, drop start and scramble inputs to prove capture.
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        launch(f, a, b);
        @(posedge clk);
        #1;
        if (is_special(f, a, b)) chk("imm_done", 32'(bus.done), 32'd1);
        else                     chk("busy_after_e0", 32'(bus.busy), 32'd1);
        bus.start    = 1'b0;
        bus.op1      = $urandom;
        bus.op2      = $urandom;
        bus.div_func = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: check result and busy timing on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=%h required=no_done", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", bus.result, e.res);
                    chk("busy_cycles", 32'(busy_cnt), e.special ? 32'd0 : 32'd32);
                    chk("busy_before_done", 32'(prev_busy), e.special ? 32'd0 : 32'd1);
                    last_res = e.res;
                end
                busy_cnt = 0;
            end else if (bus.busy) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.div_func = 2'b00;
        bus.op1      = 32'd0;
        bus.op2      = 32'd0;
        #23;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner operands.
        issue(2'b01, 32'd100, 32'd7);               wait_idle();
        issue(2'b11, 32'd100, 32'd7);               wait_idle();
        issue(2'b00, 32'hFFFF_FFF9, 32'd2);         wait_idle();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_idle();
        issue(2'b00, 32'd7, 32'hFFFF_FFFE);         wait_idle();
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);         wait_idle();
        issue(2'b01, 32'd5, 32'd0);                 wait_idle();
        issue(2'b10, 32'd5, 32'd0);                 wait_idle();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(2'b01, 32'hFFFF_FFFF, 32'd1);         wait_idle();

        // Flush at E10: no done, result kept, next request completes.
        issue(2'b01, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_done", 32'(bus.done), 32'd0);
        chk("flush_result", bus.result, last_res);
        void'(exp_q.pop_back());
        issue(2'b01, 32'd100, 32'd7);
        wait_idle();

        // Flush wins over start in IDLE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op1   = 32'd9;
        bus.op2   = 32'd3;
        @(posedge clk);
        #1;
        chk("flush_prio_busy", 32'(bus.busy), 32'd0);
        chk("flush_prio_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);

        // Start held through an op: not accepted in DONE.
        launch(2'b00, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk("held_done_seen", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("held_no_accept_busy", 32'(bus.busy), 32'd0);
        chk("held_no_accept_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        wait_idle();

        // Reset at E15 with start held: outputs clear at once, no done.
        launch(2'b01, 32'd1000, 32'd3);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_done", 32'(bus.done), 32'd0);
        chk("rstmid_result", bus.result, 32'd0);
        void'(exp_q.pop_back());
        last_res = 32'd0;
        @(negedge clk);
        chk("rstmid_hold_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.res     = ref_op(2'b01, 32'd1000, 32'd3);
            e.special = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("post_rst_accept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_idle();

        // Randomized operations with biased corner operands.
        for (int n = 0; n < 40; n++) begin
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                4: begin a = 32'($urandom_range(0, 20)); b = $urandom; end
                default: b = $urandom;
            endcase
            issue(f, a, b);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port div_func  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 SHALL have port op1  input  32  dividend.
REQ-007 SHALL have port op2  input  32  divisor.
REQ-008 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-009 SHALL have port busy  output  1  high while in CALC.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 SHALL have port result  output  32  quotient or remainder per div_func.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; DONE always returns to IDLE on the next edge.
REQ-013 SHALL, at edge E0 with state IDLE, start=1, flush=0, capture op1, op2 and div_func into internal registers; later input changes SHALL NOT affect the operation.
REQ-014 SHALL treat op2==0 as a special case: at E0 go directly to DONE; quotient 0xFFFFFFFF, remainder op1 (both signed and unsigned).
REQ-015 SHALL treat signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF) as a special case: at E0 go directly to DONE; quotient 0x80000000, remainder 0.
REQ-016 SHALL otherwise enter CALC at E0, perform one restoring-division iteration per edge on E1..E32 using a 6-bit iteration counter, and enter DONE at E32.
REQ-017 SHALL, for DIV/REM, divide absolute values, negate quotient when operand signs differ, and give remainder the sign of the dividend; DIVU/REMU use raw unsigned values.
REQ-018 SHALL hold result stable from the done cycle until the next done pulse; done=1 for exactly one cycle per completed operation.
REQ-019 SHALL assert busy=1 exactly in CALC (cycles after E0 through E32); busy=0 in IDLE and DONE.
REQ-020 SHALL ignore start when state is CALC or DONE (no queuing); a start asserted in the DONE cycle is not accepted.
REQ-021 SHALL, on flush=1 at any edge, go to IDLE with done=0 and busy=0 after that edge; result keeps its previous value.
REQ-022 SHALL give flush priority over start when both are high in IDLE (request dropped).
REQ-023 SHALL perform all internal arithmetic at 33 bits for the partial remainder to avoid sign loss.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, result=0x00000000, counter=0, independent of clk.
REQ-025 SHALL, on reset assertion mid-CALC, abort without a done pulse; the first start after rst_n deasserts is accepted normally.

Verification
REQ-026 SHALL cover DIVU op1=100, op2=7 -> busy high 32 cycles, done at cycle after E32, result=0x0000000E; REMU same operands -> 0x00000002.
REQ-027 SHALL cover DIV op1=0xFFFFFFF9 (-7), op2=2 -> result 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD, REM -> 0x00000001.
REQ-028 SHALL cover divide-by-zero DIVU 5/0 -> done in cycle after E0, busy never high, result 0xFFFFFFFF; REM 5/0 -> 0x00000005.
REQ-029 SHALL cover overflow DIV 0x80000000/0xFFFFFFFF -> result 0x80000000 one cycle after E0; REM -> 0x00000000.
REQ-030 SHALL cover flush at E10 of a DIVU -> no done pulse, busy=0 after E10, result unchanged, new start at next edge completes correctly.
REQ-031 SHALL cover rst_n pulsed low at E15 plus start held high in CALC/DONE -> outputs zero immediately, no done, held start not accepted until IDLE.
